// File: rtl/decode_stage.sv
// decode_stage: WAYS-wide RV32 subset decoder (R, I-ALU, LUI, LB/LW, SB/SW) feeding a DEPTH-entry bundle FIFO.
// Optional macro DECODE_ILLEGAL_EN: when defined, out_illegal flags unsupported opcode/funct3 per valid way.
module decode_stage #(
  parameter int WAYS  = 2,
  parameter int PC_W  = 12,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WAYS-1:0]      in_mask,
  input  logic [WAYS*PC_W-1:0] in_pc,
  input  logic [WAYS*32-1:0]   in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WAYS-1:0]      out_mask,
  output logic [WAYS*PC_W-1:0] out_pc,
  output logic [WAYS*32-1:0]   out_instr,
  output logic [WAYS*7-1:0]    out_c_sig,
  output logic [WAYS*3-1:0]    out_alu_sig,
  output logic [WAYS*32-1:0]   out_imm,
  output logic [WAYS*5-1:0]    out_rs1,
  output logic [WAYS*5-1:0]    out_rs2,
  output logic [WAYS*5-1:0]    out_rd,
  output logic [WAYS-1:0]      out_illegal,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_SHIFT = 3'b101;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_WORD  = 3'b010;

  // Control bits: {reg_we, alu_src_imm, mem_re, mem_we, mem_to_reg, byte_acc, rsvd}
  localparam logic [6:0] RTYPE_SIG = 7'b1000000;
  localparam logic [6:0] ITYPE_SIG = 7'b1100000;
  localparam logic [6:0] LB_SIG    = 7'b1110110;
  localparam logic [6:0] LW_SIG    = 7'b1110100;
  localparam logic [6:0] SB_SIG    = 7'b0101010;
  localparam logic [6:0] SW_SIG    = 7'b0101000;

  localparam logic [2:0] ALU_NONE        = 3'd0;
  localparam logic [2:0] ALU_ADD         = 3'd1;
  localparam logic [2:0] ALU_XOR         = 3'd2;
  localparam logic [2:0] ALU_OR          = 3'd3;
  localparam logic [2:0] ALU_AND         = 3'd4;
  localparam logic [2:0] ALU_SHIFT_RIGHT = 3'd5;
  localparam logic [2:0] ALU_SHIFT_LEFT  = 3'd6;

  logic [WAYS*7-1:0]  w_c_all;
  logic [WAYS*3-1:0]  w_alu_all;
  logic [WAYS*32-1:0] w_imm_all;
  logic [WAYS*5-1:0]  w_rs1_all;
  logic [WAYS*5-1:0]  w_rs2_all;
  logic [WAYS*5-1:0]  w_rd_all;
  logic [WAYS-1:0]    w_ill_all;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_dec
      logic [31:0] w_ins;
      logic [6:0]  w_op;
      logic [2:0]  w_f3;
      logic [6:0]  w_c;
      logic [2:0]  w_alu;
      logic [31:0] w_imm;
      logic        w_ill;

      assign w_ins = in_instr[gi*32 +: 32];
      assign w_op  = w_ins[6:0];
      assign w_f3  = w_ins[14:12];

      always_comb begin
        w_c   = 7'd0;
        w_alu = ALU_NONE;
        w_imm = 32'd0;
        case (w_op)
          OP_RTYPE: begin
            case (w_f3)
              F3_ADD:   begin w_c = RTYPE_SIG; w_alu = ALU_ADD;         end
              F3_XOR:   begin w_c = RTYPE_SIG; w_alu = ALU_XOR;         end
              F3_SHIFT: begin w_c = RTYPE_SIG; w_alu = ALU_SHIFT_RIGHT; end
              default:  begin w_c = 7'd0;      w_alu = ALU_NONE;        end
            endcase
          end
          OP_ITYPE: begin
            w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
            case (w_f3)
              F3_ADD:   begin w_c = ITYPE_SIG; w_alu = ALU_ADD;         end
              F3_SHIFT: begin w_c = ITYPE_SIG; w_alu = ALU_SHIFT_RIGHT; end
              F3_OR:    begin w_c = ITYPE_SIG; w_alu = ALU_OR;          end
              F3_AND:   begin w_c = ITYPE_SIG; w_alu = ALU_AND;         end
              default:  begin w_c = 7'd0;      w_alu = ALU_NONE;        end
            endcase
          end
          OP_LOAD: begin
            w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
            case (w_f3)
              F3_BYTE: begin w_c = LB_SIG; w_alu = ALU_ADD;  end
              F3_WORD: begin w_c = LW_SIG; w_alu = ALU_ADD;  end
              default: begin w_c = 7'd0;   w_alu = ALU_NONE; end
            endcase
          end
          OP_STORE: begin
            w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            case (w_f3)
              F3_BYTE: begin w_c = SB_SIG; w_alu = ALU_ADD;  end
              F3_WORD: begin w_c = SW_SIG; w_alu = ALU_ADD;  end
              default: begin w_c = 7'd0;   w_alu = ALU_NONE; end
            endcase
          end
          OP_LUI: begin
            w_imm = {{12{w_ins[31]}}, w_ins[31:12]};
            w_alu = ALU_SHIFT_LEFT;
          end
          default: begin
            w_c   = 7'd0;
            w_alu = ALU_NONE;
            w_imm = 32'd0;
          end
        endcase
        // Idle ways carry no decode so downstream can ignore them without the mask.
        if (!in_mask[gi]) begin
          w_c   = 7'd0;
          w_alu = ALU_NONE;
          w_imm = 32'd0;
        end
      end

`ifdef DECODE_ILLEGAL_EN
      // Every supported encoding maps to a nonzero ALU op, so a zero op marks an unsupported one.
      assign w_ill = in_mask[gi] & (w_alu == ALU_NONE);
`else
      assign w_ill = 1'b0;
`endif

      assign w_c_all[gi*7 +: 7]    = w_c;
      assign w_alu_all[gi*3 +: 3]  = w_alu;
      assign w_imm_all[gi*32 +: 32] = w_imm;
      assign w_rs1_all[gi*5 +: 5]  = in_mask[gi] ? w_ins[19:15] : 5'd0;
      assign w_rs2_all[gi*5 +: 5]  = in_mask[gi] ? w_ins[24:20] : 5'd0;
      assign w_rd_all[gi*5 +: 5]   = in_mask[gi] ? w_ins[11:7]  : 5'd0;
      assign w_ill_all[gi]         = w_ill;
    end
  endgenerate

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  logic [WAYS-1:0]      r_mem_mask [DEPTH];
  logic [WAYS*PC_W-1:0] r_mem_pc   [DEPTH];
  logic [WAYS*32-1:0]   r_mem_ins  [DEPTH];
  logic [WAYS*7-1:0]    r_mem_c    [DEPTH];
  logic [WAYS*3-1:0]    r_mem_alu  [DEPTH];
  logic [WAYS*32-1:0]   r_mem_imm  [DEPTH];
  logic [WAYS*5-1:0]    r_mem_rs1  [DEPTH];
  logic [WAYS*5-1:0]    r_mem_rs2  [DEPTH];
  logic [WAYS*5-1:0]    r_mem_rd   [DEPTH];
  logic [WAYS-1:0]      r_mem_ill  [DEPTH];

  // Ready looks only at registered occupancy, never at out_ready.
  assign in_ready  = !rst && !flush && (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem_mask[e] <= '0;
        r_mem_pc[e]   <= '0;
        r_mem_ins[e]  <= '0;
        r_mem_c[e]    <= '0;
        r_mem_alu[e]  <= '0;
        r_mem_imm[e]  <= '0;
        r_mem_rs1[e]  <= '0;
        r_mem_rs2[e]  <= '0;
        r_mem_rd[e]   <= '0;
        r_mem_ill[e]  <= '0;
      end
    end else if (w_push) begin
      r_mem_mask[r_wr_ptr] <= in_mask;
      r_mem_pc[r_wr_ptr]   <= in_pc;
      r_mem_ins[r_wr_ptr]  <= in_instr;
      r_mem_c[r_wr_ptr]    <= w_c_all;
      r_mem_alu[r_wr_ptr]  <= w_alu_all;
      r_mem_imm[r_wr_ptr]  <= w_imm_all;
      r_mem_rs1[r_wr_ptr]  <= w_rs1_all;
      r_mem_rs2[r_wr_ptr]  <= w_rs2_all;
      r_mem_rd[r_wr_ptr]   <= w_rd_all;
      r_mem_ill[r_wr_ptr]  <= w_ill_all;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_mask    = r_mem_mask[r_rd_ptr];
  assign out_pc      = r_mem_pc[r_rd_ptr];
  assign out_instr   = r_mem_ins[r_rd_ptr];
  assign out_c_sig   = r_mem_c[r_rd_ptr];
  assign out_alu_sig = r_mem_alu[r_rd_ptr];
  assign out_imm     = r_mem_imm[r_rd_ptr];
  assign out_rs1     = r_mem_rs1[r_rd_ptr];
  assign out_rs2     = r_mem_rs2[r_rd_ptr];
  assign out_rd      = r_mem_rd[r_rd_ptr];
  assign out_illegal = r_mem_ill[r_rd_ptr];

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, buffered successor to the combinational decode block: decodes up to WAYS RV32 instructions per cycle (R-type, I-type ALU, LUI, LB/LW, SB/SW) into control signals, ALU op, immediate and register specifiers. Decoded bundles are held in a DEPTH-entry FIFO with valid/ready handshakes on both sides. The block sits between fetch and rename/dispatch and decouples fetch from back-end stalls. It supports a single-cycle pipeline flush.

## Interface
- WAYS, 2, instructions per bundle (1..4).
- PC_W, 12, PC width.
- DEPTH, 4, bundle FIFO entries (power of two, 2..16).
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered bundles.
- in_valid  in  1  fetch bundle present.
- in_ready  out  1  block can accept a bundle this cycle.
- in_mask  in  WAYS  per-way instruction valid.
- in_pc  in  WAYS*PC_W  per-way PC; way 0 in the LSBs.
- in_instr  in  WAYS*32  per-way instruction word.
- out_valid  out  1  head bundle present.
- out_ready  in  1  consumer takes the head bundle.
- out_mask  out  WAYS  per-way valid of the head bundle.
- out_pc  out  WAYS*PC_W  passed-through PC.
- out_instr  out  WAYS*32  passed-through instruction.
- out_c_sig  out  WAYS*7  control signals, encodings per constants.v.
- out_alu_sig  out  WAYS*3  ALU op, encodings per constants.v.
- out_imm  out  WAYS*32  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  WAYS*5 each  instr[19:15], [24:20], [11:7].
- out_illegal  out  WAYS  unsupported opcode/funct3.
- count  out  CNT_W  FIFO occupancy.

## Operation
- Per-way decode is combinational on the input side. Results, together with mask, PC and instr, are written into the FIFO entry at the write pointer.
- Control decode:
  - RTYPE → `RTYPE_SIG`
  - ITYPE → `ITYPE_SIG`
  - LOAD funct3 BYTE/WORD → `LB_SIG`/`LW_SIG`
  - STORE funct3 BYTE/WORD → `SB_SIG`/`SW_SIG`
  - any other opcode → 0
- ALU decode:
  - LOAD/STORE → `ADD`
  - LUI → `SHIFT_LEFT`
  - RTYPE: XOR → `XOR`; ADD → `ADD`; SHIFT → `SHIFT_RIGHT`
  - ITYPE: SHIFT → `SHIFT_RIGHT`; OR → `OR`; ADD → `ADD`; AND → `AND`
  - any other opcode → 0
- Immediates:
  - R → 0
  - I/LOAD → sext(instr[31:20])
  - STORE → sext({instr[31:25], instr[11:7]})
  - LUI → sext(instr[31:12]) to 32 bits
  - other → 0
- Unsupported funct3 within a supported opcode, and any unsupported opcode, set c_sig=0 and alu_sig=0, and assert illegal (see Configuration). No simulation messages are printed.
- Ways with in_mask=0 store all decoded fields as 0 with illegal=0; their PC and instr are still stored.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Pointers wrap modulo DEPTH.
- in_ready = !rst & !flush & (count < DEPTH). It depends only on registered state and flush, never on out_ready, so a full FIFO with a same-cycle pop still refuses the push.
- out_valid = (count != 0). All out_* data come from the head entry's registers.
- Push without pop: count+1. Pop without push: count−1. Both: count unchanged, head and tail pointers both advance.
- Flush: at the clock edge, count, read pointer and write pointer go to 0. Flush overrides push and pop in the same cycle. Entry contents are not cleared.

## Timing
- Reset, sampled on the clock edge, drives:
  - count = 0, pointers = 0, all FIFO entries = 0.
  - out_valid = 0, all out_* data = 0.
  - in_ready = 0 while rst is high, 1 on the first cycle after release.
- Latency: a bundle pushed at edge N is visible with out_valid=1 after edge N. There is no combinational in→out path.
- Throughput: one bundle per cycle, sustained, when out_ready is held high.
- out_* data stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation behaves exactly as initial reset. Partially consumed state is lost.

## Configuration
- DECODE_ILLEGAL_EN defined: out_illegal[w] = in_mask[w] & (unsupported opcode or unsupported funct3), stored with the bundle.
- DECODE_ILLEGAL_EN undefined: out_illegal is tied to 0. Decode of unsupported encodings still yields c_sig=0, alu_sig=0, imm per the opcode rule.

## Test plan
- Reset, then push way0 `add` (0x003100B3) at PC 0x004 with mask=01 → next cycle out_valid=1, c_sig=`RTYPE_SIG`, alu_sig=`ADD`, imm=0, rd=1, rs1=2, rs2=3.
- Push 2-way bundle {`lw` x5,-4(x6) = 0xFFC32283, `sb` x7,-1(x8) = 0xFE740FA3} → way0 `LW_SIG`, `ADD`, imm=0xFFFFFFFC; way1 `SB_SIG`, `ADD`, imm=0xFFFFFFFF.
- Hold out_ready=0 and push DEPTH bundles → count=DEPTH, in_ready=0. Then pop and push in the same cycle while full → the push is refused, count=DEPTH−1 afterwards, FIFO order preserved across pointer wrap.
- With 3 bundles buffered, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, the pushed bundle is dropped.
- Push `0x0000700B` (unsupported opcode) and RTYPE funct3=110 → c_sig=0, alu_sig=0; out_illegal=1 with DECODE_ILLEGAL_EN, 0 without.
- Continuous valid/ready with random out_ready stalls over 1000 bundles → scoreboard matches the decode model, no drops or duplicates.
